spi_master: RTL and testbench

Serializing SPI-style transmitter that drives the `send` / `slave_select` / `MOSI` bus consumed by `slave1` and `slave2`. It accepts WIDTH-bit commands through a valid/ready port into a small command FIFO. Each command is shifted out LSB-first, one bit per `clkb` cycle, so the addressed slave's shift register ends holding exactly the command data. It sits between the board-level control logic (switches/buttons) and the slave instances, on the same `clkb` domain.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_cmd_fifo.sv | 57 +++++
 rtl/spi_master.sv | 136 +++++++++++++
 tb/tb_spi_master.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI-style command serializer
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } spi_state_e;

    localparam logic TGT_SLAVE1 = 1'b1;
    localparam logic TGT_SLAVE2 = 1'b0;

    localparam int DEFAULT_WIDTH = 3;

endpackage

// File: rtl/spi_cmd_fifo.sv
// rtl/spi_cmd_fifo.sv - synchronous command FIFO, DEPTH entries of DW bits
module spi_cmd_fifo #(
    parameter int DW    = 4,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - queued LSB-first serializer driving send/slave_select/MOSI
module spi_master
    import spi_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GAP   = 2,
    parameter int DEPTH = 2
) (
    input  logic             clkb,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_target,
    output logic             send,
    output logic             slave_select,
    output logic             MOSI,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(GAP + 1);

    spi_state_e       state_q, state_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [GW-1:0]    gapcnt_q, gapcnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             send_q, send_d;
    logic             mosi_q, mosi_d;
    logic             ss_q, ss_d;
    logic             done_q, done_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH:0]   fifo_rdata;

    assign fifo_push = cmd_valid && cmd_ready;
    assign cmd_ready = !fifo_full;

    // Payload is {target, data} so both are frozen at the accept edge.
    spi_cmd_fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clkb),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({cmd_target, cmd_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;
        shreg_d  = shreg_q;
        send_d   = send_q;
        mosi_d   = mosi_q;
        ss_d     = ss_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata[WIDTH-1:0] >> 1;
                    mosi_d   = fifo_rdata[0];
                    ss_d     = fifo_rdata[WIDTH];
                    send_d   = 1'b1;
                    bitcnt_d = CW'(1);
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bitcnt_q == CW'(WIDTH)) begin
                    send_d   = 1'b0;
                    mosi_d   = 1'b0;
                    done_d   = 1'b1;
                    gapcnt_d = GW'(GAP - 1);
                    if (GAP == 1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    mosi_d   = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = bitcnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                // The IDLE cycle that follows supplies the last low cycle of the gap.
                gapcnt_d = gapcnt_q - GW'(1);
                if (gapcnt_q <= GW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkb) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            shreg_q  <= '0;
            send_q   <= 1'b0;
            mosi_q   <= 1'b0;
            ss_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            shreg_q  <= shreg_d;
            send_q   <= send_d;
            mosi_q   <= mosi_d;
            ss_q     <= ss_d;
            done_q   <= done_d;
        end
    end

    assign send         = send_q;
    assign MOSI         = mosi_q;
    assign slave_select = ss_q;
    assign done         = done_q;
    assign busy         = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - randomized bench for spi_master against a slot-position reference model
module tb_spi_master;
    import spi_pkg::*;

    localparam int W = 3;
    localparam int G = 2;
    localparam int D = 2;

    logic         clkb = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_data;
    logic         cmd_target;
    logic         send;
    logic         slave_select;
    logic         MOSI;
    logic         busy;
    logic         done;

    always #5 clkb = ~clkb;

    spi_master #(.WIDTH(W), .GAP(G), .DEPTH(D)) dut (
        .clkb         (clkb),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .cmd_target   (cmd_target),
        .send         (send),
        .slave_select (slave_select),
        .MOSI         (MOSI),
        .busy         (busy),
        .done         (done)
    );

    // Simple slave registers: shift MOSI in at the MSB while send is high.
    logic [W-1:0] led1 = '0;
    logic [W-1:0] led2 = '0;
    always @(posedge clkb) begin
        if (send) begin
            if (slave_select == TGT_SLAVE1) led1 <= {MOSI, led1[W-1:1]};
            else                            led2 <= {MOSI, led2[W-1:1]};
        end
    end

    typedef struct {
        logic [W-1:0] data;
        logic         tgt;
    } cmd_t;

    cmd_t pend[$];
    cmd_t cur;
    int   pos = -1;
    logic e_send = 1'b0, e_mosi = 1'b0, e_ss = 1'b0, e_done = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // One clock: drive inputs, check ready, advance the model across the edge, check outputs.
    task automatic step(input logic v, input logic [W-1:0] d, input logic t, input logic r);
        cmd_t nc;
        bit   acc;
        bit   e_busy;
        cmd_valid  = v;
        cmd_data   = d;
        cmd_target = t;
        reset      = r;
        check("cmd_ready", 32'(cmd_ready), 32'(pend.size() < D));
        acc     = v && (pend.size() < D) && !r;
        nc.data = d;
        nc.tgt  = t;
        @(posedge clkb);
        if (r) begin
            pend.delete();
            pos    = -1;
            e_send = 1'b0;
            e_mosi = 1'b0;
            e_ss   = 1'b0;
            e_done = 1'b0;
        end else begin
            if (pos < 0 || pos >= W + G) begin
                if (pend.size() > 0) begin
                    cur  = pend.pop_front();
                    pos  = 1;
                    e_ss = cur.tgt;
                end else begin
                    pos = -1;
                end
            end else begin
                pos++;
            end
            if (acc) pend.push_back(nc);
            e_send = (pos >= 1 && pos <= W);
            e_mosi = e_send ? cur.data[pos-1] : 1'b0;
            e_done = (pos == W + 1);
        end
        e_busy = (pos >= 1 && pos < W + G) || (pend.size() > 0);
        #1;
        check("send", 32'(send), 32'(e_send));
        check("MOSI", 32'(MOSI), 32'(e_mosi));
        check("slave_select", 32'(slave_select), 32'(e_ss));
        check("done", 32'(done), 32'(e_done));
        check("busy", 32'(busy), 32'(e_busy));
        if (e_done) begin
            if (cur.tgt) check("led1", 32'(led1), 32'(cur.data));
            else         check("led2", 32'(led2), 32'(cur.data));
        end
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_data   = '0;
        cmd_target = 1'b0;
        repeat (2) @(posedge clkb);
        #1;
        step(1'b0, 3'b000, 1'b0, 1'b1);

        step(1'b1, 3'b101, 1'b1, 1'b0);
        repeat (7) step(1'b0, 3'b000, 1'b0, 1'b0);
        check("led2_untouched", 32'(led2), 32'h0);

        step(1'b1, 3'b110, 1'b0, 1'b0);
        repeat (7) step(1'b0, $urandom_range(0, 7), 1'b1, 1'b0);
        check("led1_untouched", 32'(led1), 32'h5);

        step(1'b1, 3'b011, 1'b1, 1'b0);
        step(1'b1, 3'b100, 1'b0, 1'b0);
        step(1'b1, 3'b111, 1'b1, 1'b0);
        step(1'b1, 3'b001, 1'b0, 1'b0);
        repeat (20) step(1'b0, 3'b000, 1'b0, 1'b0);

        step(1'b1, 3'b010, 1'b1, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b1);
        step(1'b1, 3'b110, 1'b1, 1'b0);
        repeat (8) step(1'b0, 3'b000, 1'b0, 1'b0);

        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 1)), W'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 79) == 0));
        end
        repeat (12) step(1'b0, 3'b000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
